// File: rtl/slcg_wake_ctrl.sv
// slcg_wake_ctrl: per-client SLCG enable sequencing.
// Each client runs OFF -> WAKE -> ON -> HOLD -> OFF. A round-robin arbiter admits
// one wake-up at a time to bound di/dt. HOLD keeps the clock running for a
// programmable idle hysteresis after activity stops.
//
// state | meaning
// ------+------------------------------------------------------------
// OFF   | gating cell disabled (unless override), waiting for req|busy
// WAKE  | clock enabled, counting WAKE_CYC cycles before ack
// ON    | clock stable, ack asserted, client active
// HOLD  | client idle, ack held, counting down idle hysteresis
module slcg_wake_ctrl #(
    parameter int NUM_CLIENTS = 4,
    parameter int WAKE_CYC    = 4
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic [NUM_CLIENTS-1:0] client_req,
    input  logic [NUM_CLIENTS-1:0] client_busy,
    input  logic                   cfg_clk_ovr_on,
    input  logic [7:0]             cfg_idle_cyc,
    output logic [NUM_CLIENTS-1:0] clk_en,
    output logic [NUM_CLIENTS-1:0] client_ack,
    output logic                   wake_active,
    output logic                   all_off
);

    localparam int WCW = $clog2(WAKE_CYC + 1);
    localparam int RRW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           state_q [NUM_CLIENTS];
    state_t           state_d [NUM_CLIENTS];
    logic [WCW-1:0]   wcnt_q  [NUM_CLIENTS];
    logic [WCW-1:0]   wcnt_d  [NUM_CLIENTS];
    logic [7:0]       icnt_q  [NUM_CLIENTS];
    logic [7:0]       icnt_d  [NUM_CLIENTS];
    logic [RRW-1:0]   rr_q;
    logic [RRW-1:0]   rr_d;

    logic [NUM_CLIENTS-1:0] clk_en_q, clk_en_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic                   wake_active_q, wake_active_d;
    logic                   all_off_q, all_off_d;

    logic [NUM_CLIENTS-1:0] active;
    logic                   wake_blocking;
    logic                   gnt_vld;
    logic [RRW-1:0]         gnt_idx;
    int                     scan_idx;

    assign active = client_req | client_busy;

    // A WAKE client on its last count leaves this cycle, so it no longer blocks
    // the arbiter; this lets the next grant land on the same edge it reaches ON.
    always_comb begin
        wake_blocking = 1'b0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (state_q[c] == ST_WAKE && wcnt_q[c] != '0) begin
                wake_blocking = 1'b1;
            end
        end
    end

    // Round-robin search from rr for the first OFF client wanting its clock.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        if (!wake_blocking && !cfg_clk_ovr_on) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                scan_idx = (int'(rr_q) + i) % NUM_CLIENTS;
                if (!gnt_vld && state_q[scan_idx] == ST_OFF && active[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = RRW'(scan_idx);
                end
            end
        end
        rr_d = gnt_vld ? RRW'((int'(gnt_idx) + 1) % NUM_CLIENTS) : rr_q;
    end

    // Per-client next state, counters and the output values they imply.
    always_comb begin
        wake_active_d = 1'b0;
        all_off_d     = 1'b1;
        clk_en_d      = '0;
        ack_d         = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            state_d[c] = state_q[c];
            wcnt_d[c]  = wcnt_q[c];
            icnt_d[c]  = icnt_q[c];
            case (state_q[c])
                ST_OFF: begin
                    if (active[c]) begin
                        if (cfg_clk_ovr_on) begin
                            state_d[c] = ST_ON;
                        end else if (gnt_vld && gnt_idx == c[RRW-1:0]) begin
                            state_d[c] = ST_WAKE;
                            wcnt_d[c]  = WAKE_LOAD;
                        end
                    end
                end
                ST_WAKE: begin
                    if (wcnt_q[c] == '0) begin
                        state_d[c] = ST_ON;
                    end else begin
                        wcnt_d[c] = wcnt_q[c] - 1'b1;
                    end
                end
                ST_ON: begin
                    if (!active[c]) begin
                        state_d[c] = ST_HOLD;
                        icnt_d[c]  = cfg_idle_cyc;
                    end
                end
                ST_HOLD: begin
                    // Activity wins over an expiring counter; override freezes the countdown.
                    if (active[c]) begin
                        state_d[c] = ST_ON;
                    end else if (!cfg_clk_ovr_on) begin
                        if (icnt_q[c] == 8'd0) begin
                            state_d[c] = ST_OFF;
                        end else begin
                            icnt_d[c] = icnt_q[c] - 8'd1;
                        end
                    end
                end
                default: state_d[c] = ST_OFF;
            endcase
            clk_en_d[c] = (state_d[c] != ST_OFF) | cfg_clk_ovr_on;
            ack_d[c]    = (state_d[c] == ST_ON) || (state_d[c] == ST_HOLD);
            if (state_d[c] == ST_WAKE) begin
                wake_active_d = 1'b1;
            end
            if (state_d[c] != ST_OFF) begin
                all_off_d = 1'b0;
            end
        end
    end

    // State, counters, rr pointer and registered outputs; reset clears everything.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                state_q[c] <= ST_OFF;
                wcnt_q[c]  <= '0;
                icnt_q[c]  <= 8'd0;
            end
            rr_q          <= '0;
            clk_en_q      <= '0;
            ack_q         <= '0;
            wake_active_q <= 1'b0;
            all_off_q     <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                state_q[c] <= state_d[c];
                wcnt_q[c]  <= wcnt_d[c];
                icnt_q[c]  <= icnt_d[c];
            end
            rr_q          <= rr_d;
            clk_en_q      <= clk_en_d;
            ack_q         <= ack_d;
            wake_active_q <= wake_active_d;
            all_off_q     <= all_off_d;
        end
    end

    assign clk_en      = clk_en_q;
    assign client_ack  = ack_q;
    assign wake_active = wake_active_q;
    assign all_off     = all_off_q;

endmodule

// File: tb/tb_slcg_wake_ctrl.sv
// Directed bench for slcg_wake_ctrl (NUM_CLIENTS=4, WAKE_CYC=4).
module tb_slcg_wake_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] busy;
    logic       ovr;
    logic [7:0] idle;
    logic [3:0] clk_en;
    logic [3:0] ack;
    logic       wake_active;
    logic       all_off;

    int checks;
    int failures;

    slcg_wake_ctrl #(.NUM_CLIENTS(4), .WAKE_CYC(4)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .client_req     (req),
        .client_busy    (busy),
        .cfg_clk_ovr_on (ovr),
        .cfg_idle_cyc   (idle),
        .clk_en         (clk_en),
        .client_ack     (ack),
        .wake_active    (wake_active),
        .all_off        (all_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; busy = '0; ovr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Drives req for a single client from OFF through edge t+4 (ack visible).
    task automatic wake_client(input logic [3:0] m);
        req = m;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; busy = '0; ovr = 1'b0; idle = 8'd3;
        tick(); tick();
        checks++;
        if (clk_en !== 4'b0000 || ack !== 4'b0000 || wake_active !== 1'b0 || all_off !== 1'b1) begin
            failures++;
            $display("FAIL reset_vals: got en=%b ack=%b wa=%b ao=%b exp en=0000 ack=0000 wa=0 ao=1",
                     clk_en, ack, wake_active, all_off);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_wake();
        do_reset();
        idle = 8'd3;
        req = 4'b0001;
        tick();
        checks++;
        if (clk_en !== 4'b0001 || wake_active !== 1'b1 || ack !== 4'b0000 || all_off !== 1'b0) begin
            failures++;
            $display("FAIL single_t1: got en=%b wa=%b ack=%b ao=%b exp en=0001 wa=1 ack=0000 ao=0",
                     clk_en, wake_active, ack, all_off);
        end
        repeat (2) tick();
        tick();
        checks++;
        if (ack !== 4'b0000 || wake_active !== 1'b1) begin
            failures++;
            $display("FAIL single_t3: got ack=%b wa=%b exp ack=0000 wa=1", ack, wake_active);
        end
        tick();
        checks++;
        if (ack !== 4'b0001 || wake_active !== 1'b0 || clk_en !== 4'b0001) begin
            failures++;
            $display("FAIL single_t4: got ack=%b wa=%b en=%b exp ack=0001 wa=0 en=0001", ack, wake_active, clk_en);
        end
        repeat (5) tick();
        req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (clk_en !== 4'b0001 || ack !== 4'b0001) begin
                failures++;
                $display("FAIL single_hold s+%0d: got en=%b ack=%b exp en=0001 ack=0001", k, clk_en, ack);
            end
        end
        tick();
        checks++;
        if (clk_en !== 4'b0000 || ack !== 4'b0000 || all_off !== 1'b1) begin
            failures++;
            $display("FAIL single_off: got en=%b ack=%b ao=%b exp en=0000 ack=0000 ao=1", clk_en, ack, all_off);
        end
    endtask

    // All four request at t; order[] is the expected grant sequence.
    task automatic run_round(input int o0, input int o1, input int o2, input int o3, input string tag);
        int         order [4];
        logic [3:0] exp_ack;
        logic [3:0] exp_en;
        int         n;
        order[0] = o0; order[1] = o1; order[2] = o2; order[3] = o3;
        req = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            tick();
            n = k / 4;
            exp_ack = '0;
            exp_en  = '0;
            for (int j = 0; j < 4; j++) begin
                if (j < n) exp_ack[order[j]] = 1'b1;
                if (j <= n) exp_en[order[j]] = 1'b1;
            end
            checks++;
            if (ack !== exp_ack || clk_en !== exp_en || wake_active !== (k < 16)) begin
                failures++;
                $display("FAIL %s t+%0d: got ack=%b en=%b wa=%b exp ack=%b en=%b wa=%b",
                         tag, k, ack, clk_en, wake_active, exp_ack, exp_en, (k < 16));
            end
        end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        idle = 8'd0;
        run_round(0, 1, 2, 3, "rr_round1");
        wake_client(4'b0010);
        req = 4'b0000;
        tick(); tick();
        checks++;
        if (all_off !== 1'b1) begin
            failures++;
            $display("FAIL rr_setup: got ao=%b exp ao=1", all_off);
        end
        run_round(2, 3, 0, 1, "rr_round2");
    endtask

    task automatic test_hold_react();
        logic ok;
        do_reset();
        idle = 8'd8;
        wake_client(4'b0001);
        req = 4'b0000;
        ok = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 4) busy = 4'b0001;
            if (clk_en !== 4'b0001 || ack !== 4'b0001) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hold_react_cont: got drop in en/ack en=%b ack=%b exp en=0001 ack=0001", clk_en, ack);
        end
        busy = 4'b0000;
        repeat (9) tick();
        checks++;
        if (clk_en !== 4'b0001 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL hold_react_reload: got en=%b ack=%b exp en=0001 ack=0001", clk_en, ack);
        end
        tick();
        checks++;
        if (clk_en !== 4'b0000 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL hold_react_off: got en=%b ack=%b exp en=0000 ack=0000", clk_en, ack);
        end
    endtask

    task automatic test_override();
        logic wa_seen;
        do_reset();
        idle = 8'd2;
        ovr = 1'b1;
        tick();
        checks++;
        if (clk_en !== 4'b1111 || ack !== 4'b0000 || all_off !== 1'b1) begin
            failures++;
            $display("FAIL ovr_on: got en=%b ack=%b ao=%b exp en=1111 ack=0000 ao=1", clk_en, ack, all_off);
        end
        req = 4'b0100;
        wa_seen = 1'b0;
        tick();
        wa_seen = wa_seen | wake_active;
        checks++;
        if (ack !== 4'b0100 || clk_en !== 4'b1111) begin
            failures++;
            $display("FAIL ovr_ack: got ack=%b en=%b exp ack=0100 en=1111", ack, clk_en);
        end
        tick();
        wa_seen = wa_seen | wake_active;
        req = 4'b0000;
        repeat (5) begin
            tick();
            wa_seen = wa_seen | wake_active;
        end
        checks++;
        if (wa_seen !== 1'b0) begin
            failures++;
            $display("FAIL ovr_no_wake: got wa_seen=%b exp 0", wa_seen);
        end
        checks++;
        if (ack !== 4'b0100) begin
            failures++;
            $display("FAIL ovr_hold_frozen: got ack=%b exp ack=0100", ack);
        end
        ovr = 1'b0;
        tick();
        checks++;
        if (clk_en !== 4'b0100) begin
            failures++;
            $display("FAIL ovr_deassert: got en=%b exp en=0100", clk_en);
        end
        tick();
        checks++;
        if (clk_en !== 4'b0100 || ack !== 4'b0100) begin
            failures++;
            $display("FAIL ovr_resume: got en=%b ack=%b exp en=0100 ack=0100", clk_en, ack);
        end
        tick();
        checks++;
        if (clk_en !== 4'b0000 || all_off !== 1'b1) begin
            failures++;
            $display("FAIL ovr_hold_off: got en=%b ao=%b exp en=0000 ao=1", clk_en, all_off);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        idle = 8'd20;
        wake_client(4'b1000);
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick(); tick();
        checks++;
        if (clk_en !== 4'b1010 || wake_active !== 1'b1 || ack !== 4'b1000) begin
            failures++;
            $display("FAIL rstmid_pre: got en=%b wa=%b ack=%b exp en=1010 wa=1 ack=1000", clk_en, wake_active, ack);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (clk_en !== 4'b0000 || ack !== 4'b0000 || wake_active !== 1'b0 || all_off !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_vals: got en=%b ack=%b wa=%b ao=%b exp en=0000 ack=0000 wa=0 ao=1",
                     clk_en, ack, wake_active, all_off);
        end
        rst = 1'b0;
        req = 4'b1010;
        tick();
        checks++;
        if (clk_en !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_rr: got en=%b exp en=0010", clk_en);
        end
        ovr = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (clk_en !== 4'b0000 || all_off !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ovr: got en=%b ao=%b exp en=0000 ao=1", clk_en, all_off);
        end
        rst = 1'b0; ovr = 1'b0; req = 4'b0000;
    endtask

    task automatic test_busy_wins();
        do_reset();
        idle = 8'd1;
        wake_client(4'b0001);
        req = 4'b0000;
        tick(); tick();
        busy = 4'b0001;
        tick();
        checks++;
        if (clk_en !== 4'b0001 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL busy_wins: got en=%b ack=%b exp en=0001 ack=0001", clk_en, ack);
        end
        busy = 4'b0000;
        tick(); tick();
        checks++;
        if (clk_en !== 4'b0001) begin
            failures++;
            $display("FAIL busy_wins_reload: got en=%b exp en=0001", clk_en);
        end
        tick();
        checks++;
        if (clk_en !== 4'b0000) begin
            failures++;
            $display("FAIL busy_wins_off: got en=%b exp en=0000", clk_en);
        end
    endtask

    task automatic test_idle_bounds();
        do_reset();
        idle = 8'd0;
        wake_client(4'b0001);
        req = 4'b0000;
        tick();
        checks++;
        if (clk_en !== 4'b0001 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL idle0_hold: got en=%b ack=%b exp en=0001 ack=0001", clk_en, ack);
        end
        tick();
        checks++;
        if (clk_en !== 4'b0000 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL idle0_off: got en=%b ack=%b exp en=0000 ack=0000", clk_en, ack);
        end
        do_reset();
        idle = 8'd255;
        wake_client(4'b0001);
        req = 4'b0000;
        repeat (256) tick();
        checks++;
        if (clk_en !== 4'b0001 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL idle255_hold: got en=%b ack=%b exp en=0001 ack=0001", clk_en, ack);
        end
        tick();
        checks++;
        if (clk_en !== 4'b0000 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL idle255_off: got en=%b ack=%b exp en=0000 ack=0000", clk_en, ack);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        req  = '0;
        busy = '0;
        ovr  = 1'b0;
        idle = 8'd0;
        test_reset();
        test_single_wake();
        test_round_robin();
        test_hold_react();
        test_override();
        test_reset_mid();
        test_busy_wins();
        test_idle_bounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
